// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default PC vectors, sequential step and
// the redirect-buffer state encoding.
package cpu_pkg;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_4180;
  localparam int unsigned STEP_DEF      = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/pc_unit.sv
// Program counter with exception entry/return and a one-entry buffer holding a
// redirect that arrives while fetch is stalled. Optional macro: PC_ALIGN_CHECK_EN.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VEC = WIDTH'(RESET_VEC_DEF),
  parameter logic [WIDTH-1:0]  EXC_VEC   = WIDTH'(EXC_VEC_DEF),
  parameter int unsigned       STEP      = STEP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             redirect_pending,
  output logic             pc_misalign
);

  buf_state_t       state;
  buf_state_t       state_d;
  logic [WIDTH-1:0] buf_target;
  logic [WIDTH-1:0] pc_d;
  logic             buf_load;

  assign pc_next = pc + WIDTH'(STEP);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic: exception/eret flush the buffer, an unstalled cycle consumes it
  always_comb begin
    state_d = state;
    if (exc_req || eret) begin
      state_d = EMPTY;
    end else if (stall) begin
      if (redirect_valid) begin
        state_d = FULL;
      end
    end else begin
      state_d = EMPTY;
    end
  end

  // Output logic
  always_comb begin
    redirect_pending = (state == FULL);
    buf_load         = stall && redirect_valid && !exc_req && !eret;
  end

  // Buffered target is data only; its validity lives in state
  always_ff @(posedge clk) begin
    if (buf_load) begin
      buf_target <= redirect_target;
    end
  end

  always_comb begin
    pc_d = pc_next;
    if (exc_req) begin
      pc_d = EXC_VEC;
    end else if (eret) begin
      pc_d = epc;
    end else if (stall) begin
      pc_d = pc;
    end else if (state == FULL) begin
      pc_d = buf_target;
    end else if (redirect_valid) begin
      pc_d = redirect_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_VEC;
    end else begin
      pc <= pc_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  assign pc_misalign = (pc[1:0] != 2'b00);
`else
  assign pc_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, reset corner cases
// and randomized stimulus against a behavioural model.
module tb_pc_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         stall;
  logic         redirect_valid;
  logic [W-1:0] redirect_target;
  logic         exc_req;
  logic         eret;
  logic [W-1:0] epc;
  logic [W-1:0] pc;
  logic [W-1:0] pc_next;
  logic         redirect_pending;
  logic         pc_misalign;

  int checks = 0;
  int errors = 0;

  pc_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc_req         (exc_req),
    .eret            (eret),
    .epc             (epc),
    .pc              (pc),
    .pc_next         (pc_next),
    .redirect_pending(redirect_pending),
    .pc_misalign     (pc_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         stall;
    logic         rv;
    logic [W-1:0] tgt;
    logic         exc;
    logic         eret;
    logic [W-1:0] epc;
    logic [W-1:0] exp_pc;
    logic         exp_pend;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state
  logic [W-1:0] m_pc;
  logic         m_full;
  logic [W-1:0] m_buf;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic exp_misalign(input logic [W-1:0] p);
`ifdef PC_ALIGN_CHECK_EN
    return p[1:0] != 2'b00;
`else
    return 1'b0 & p[0];
`endif
  endfunction

  task automatic check_outputs(input string tag, input logic [W-1:0] epc_v, input logic epend);
    chk({tag, " pc"}, pc, epc_v);
    chk({tag, " pending"}, {31'd0, redirect_pending}, {31'd0, epend});
    chk({tag, " pc_next"}, pc_next, epc_v + 32'd4);
    chk({tag, " misalign"}, {31'd0, pc_misalign}, {31'd0, exp_misalign(epc_v)});
  endtask

  task automatic drive(input logic s, input logic rv, input logic [W-1:0] t,
                       input logic e, input logic r, input logic [W-1:0] ep);
    stall = s; redirect_valid = rv; redirect_target = t;
    exc_req = e; eret = r; epc = ep;
  endtask

  task automatic add(input logic s, input logic rv, input logic [W-1:0] t,
                     input logic e, input logic r, input logic [W-1:0] ep,
                     input logic [W-1:0] xp, input logic xq);
    vec_t v;
    v.stall = s; v.rv = rv; v.tgt = t; v.exc = e; v.eret = r; v.epc = ep;
    v.exp_pc = xp; v.exp_pend = xq;
    vecs.push_back(v);
  endtask

  task automatic model_step;
    if (exc_req) begin
      m_pc = 32'h0000_4180; m_full = 1'b0;
    end else if (eret) begin
      m_pc = epc; m_full = 1'b0;
    end else if (stall) begin
      if (redirect_valid) begin
        m_full = 1'b1; m_buf = redirect_target;
      end
    end else if (m_full) begin
      m_pc = m_buf; m_full = 1'b0;
    end else if (redirect_valid) begin
      m_pc = redirect_target;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    drive(0, 0, '0, 0, 0, '0);
    reset = 1'b1;
    #2;
    check_outputs("reset", 32'h0000_3000, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    //       stall rv tgt           exc eret epc          exp_pc        pend
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3008, 0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_300C, 0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3010, 0);
    add(1, 1, 32'h3100,     0, 0, 32'h0,        32'h0000_3010, 1);
    add(0, 1, 32'h3500,     0, 0, 32'h0,        32'h0000_3100, 0);
    add(1, 1, 32'h3100,     0, 0, 32'h0,        32'h0000_3100, 1);
    add(1, 1, 32'h3200,     0, 0, 32'h0,        32'h0000_3100, 1);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3200, 0);
    add(1, 1, 32'h3300,     0, 0, 32'h0,        32'h0000_3200, 1);
    add(1, 0, 32'h0,        1, 0, 32'h0,        32'h0000_4180, 0);
    add(0, 0, 32'h0,        0, 1, 32'h3014,     32'h0000_3014, 0);
    add(0, 1, 32'h3102,     0, 0, 32'h0,        32'h0000_3102, 0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3106, 0);
    add(1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3106, 0);
    add(0, 1, 32'h3000,     0, 0, 32'h0,        32'h0000_3000, 0);
    add(1, 1, 32'h3700,     1, 1, 32'h3800,     32'h0000_4180, 0);
    add(1, 1, 32'h3700,     0, 1, 32'h3800,     32'h0000_3800, 0);
    add(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,       32'hFFFF_FFFC, 0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0000, 0);
    add(1, 1, 32'h3400,     0, 0, 32'h0,        32'h0000_0000, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].rv, vecs[i].tgt, vecs[i].exc, vecs[i].eret, vecs[i].epc);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_pend);
    end

    // Reset mid-stall must discard the buffered redirect and act immediately
    drive(1, 0, '0, 0, 0, '0);
    #2;
    reset = 1'b1;
    #1;
    check_outputs("midreset", 32'h0000_3000, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, '0, 0, 0, '0);
    @(posedge clk);
    #1;
    check_outputs("post_reset", 32'h0000_3004, 1'b0);

    // Randomized run against the model
    m_pc = pc; m_full = 1'b0; m_buf = '0;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            {$urandom_range(0, 15) == 0 ? 32'hFFFF_0000 : 32'h0000_3000, 16'd0} >> 16
              | ($urandom & 32'h0000_0FFF) | 32'h0000_3000,
            $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
            32'h0000_3000 | ($urandom & 32'h0000_0FFF));
      if ($urandom_range(0, 5) == 0) redirect_target = 32'hFFFF_FFFC;
      model_step();
      @(posedge clk);
      #1;
      check_outputs($sformatf("rand%0d", i), m_pc, m_full);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_3000, PC value on reset.
REQ-003 SHALL have parameter EXC_VEC, default 32'h0000_4180, exception handler entry.
REQ-004 SHALL have parameter STEP, default 4, sequential increment.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port stall  input  1  hold PC this cycle.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump taken.
REQ-009 SHALL have port redirect_target  input  WIDTH  branch/jump destination.
REQ-010 SHALL have port exc_req  input  1  exception/interrupt entry.
REQ-011 SHALL have port eret  input  1  return from exception.
REQ-012 SHALL have port epc  input  WIDTH  return address for eret.
REQ-013 SHALL have port pc  output  WIDTH  current fetch address, registered.
REQ-014 SHALL have port pc_next  output  WIDTH  pc+STEP, combinational.
REQ-015 SHALL have port redirect_pending  output  1  buffered redirect waiting, registered.
REQ-016 SHALL have port pc_misalign  output  1  pc low two bits nonzero.

Function
REQ-017 SHALL update pc on the rising clk edge by priority: exc_req > eret > stall > pending redirect > redirect_valid > sequential.
REQ-018 SHALL load EXC_VEC when exc_req=1, regardless of stall, and clear pending.
REQ-019 SHALL load epc when eret=1 and exc_req=0, regardless of stall, and clear pending.
REQ-020 SHALL hold pc when stall=1 and neither exc_req nor eret is asserted.
REQ-021 SHALL, when stall=1 and redirect_valid=1 with no exception or eret, latch redirect_target into a one-entry buffer and set redirect_pending next cycle.
REQ-022 SHALL, when the buffer is already full, overwrite it with a newer stalled redirect target (last wins).
REQ-023 SHALL, on the first unstalled cycle with the buffer full, load the buffered target, clear pending, and ignore any same-cycle redirect_valid.
REQ-024 SHALL load redirect_target when stall=0, buffer empty, and redirect_valid=1.
REQ-025 SHALL otherwise load pc_next.
REQ-026 SHALL compute pc_next as pc+STEP modulo 2^WIDTH, wrapping with no carry out.
REQ-027 SHALL load redirect and epc values unmodified, including misaligned values.
REQ-028 SHALL use a two-state machine: EMPTY transitions to FULL on a latched stalled redirect; FULL transitions to EMPTY on consume, exc_req, or eret.

Reset
REQ-029 SHALL, asynchronously while reset=1, force pc=RESET_VEC, redirect_pending=0, and state EMPTY.
REQ-030 SHALL discard a buffered redirect when reset is asserted mid-stall.
REQ-031 SHALL, on the first edge after reset deasserts, obey REQ-017.

Configuration
REQ-032 SHALL, with PC_ALIGN_CHECK_EN defined, drive pc_misalign=(pc[1:0]!=0) combinationally.
REQ-033 SHALL, without PC_ALIGN_CHECK_EN, keep port pc_misalign present, tie it to 0, and add no logic.

Structure
REQ-034 SHALL place default RESET_VEC, EXC_VEC, STEP, and the state enum (EMPTY, FULL) in shared package cpu_pkg.
REQ-035 SHALL be a single module; the redirect buffer is inline and needs no sub-module.

Verification
REQ-036 SHALL cover: reset pulse mid-run -> pc=0x3000 immediately; three free-running clocks -> 0x3004, 0x3008, 0x300C.
REQ-037 SHALL cover: at pc=0x3010, stall=1 with redirect to 0x3100 -> pc holds 0x3010 and pending=1; stall drops -> pc=0x3100, pending=0.
REQ-038 SHALL cover: two stalled redirects, 0x3100 then 0x3200 -> 0x3200 is taken on release.
REQ-039 SHALL cover: exc_req during stall with pending=1 -> pc=0x4180, pending=0; then eret with epc=0x3014 -> pc=0x3014.
REQ-040 SHALL cover: pc=0xFFFF_FFFC with WIDTH=32 -> next pc=0x0000_0000.
REQ-041 SHALL cover: redirect to 0x3102 with PC_ALIGN_CHECK_EN -> pc=0x3102, pc_misalign=1; without the macro -> pc_misalign=0.
